wb2sdrc_burst: RTL and testbench

Single-clock Wishbone B3 to SDRAM-controller bridge, successor of the single-beat asynchronous translator. Supports registered incrementing bursts (CTI 010): it coalesces write beats into one multi-beat SDRAM command and optionally prefetches read bursts. It sits between a Wishbone master and the SDRAM controller request/data handshake, with both sides clocked by `sdram_clk`.

---
 rtl/wb2sdrc_pkg.sv | 20 ++
 rtl/wb2sdrc_sync_fifo.sv | 53 +++++
 rtl/wb2sdrc_burst.sv | 211 +++++++++++++++++++++
 tb/tb_wb2sdrc_burst.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb2sdrc_pkg.sv
// Shared types for the wb2sdrc_burst Wishbone-to-SDRAM-controller bridge:
// FSM state encoding and Wishbone cycle-type (CTI) codes.
package wb2sdrc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_REQ,
        WR_DRAIN,
        RD_REQ,
        RD_DATA,
        RD_FLUSH
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb2sdrc_sync_fifo.sv
// Single-clock FIFO with show-ahead head, occupancy count and synchronous clear.
// Used as the write-beat buffer and the read-return FIFO of wb2sdrc_burst.
module wb2sdrc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] STEP = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + STEP;
            if (do_pop)  rp <= rp + STEP;
            if (do_push && !do_pop)      count <= count + ONE;
            else if (do_pop && !do_push) count <= count - ONE;
        end
    end

endmodule

// File: rtl/wb2sdrc_burst.sv
// Wishbone B3 to SDRAM controller bridge with write-burst coalescing.
// Define WB2SDRC_RD_PREFETCH_EN to prefetch incrementing read bursts.
module wb2sdrc_burst
    import wb2sdrc_pkg::*;
#(
    parameter int dw        = 32,
    parameter int bl        = 9,
    parameter int BURST_MAX = 8
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    input  logic [29:0]       wb_addr_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [dw/8-1:0]   wb_sel_i,
    input  logic [2:0]        wb_cti_i,
    output logic              wb_ack_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic              sdr_req,
    output logic [29:0]       sdr_req_addr,
    output logic [bl-1:0]     sdr_req_len,
    output logic              sdr_req_wr_n,
    input  logic              sdr_req_ack,
    input  logic              sdr_wr_next,
    output logic [dw/8-1:0]   sdr_wr_en_n,
    output logic [dw-1:0]     sdr_wr_data,
    input  logic              sdr_rd_valid,
    input  logic              sdr_last_rd,
    input  logic [dw-1:0]     sdr_rd_data
);

    localparam int SW = dw / 8;
    localparam int LB = $clog2(BURST_MAX);
    localparam logic [bl-1:0] BM_LEN  = bl'(BURST_MAX);
    localparam logic [bl-1:0] LEN_ONE = bl'(1);
    localparam logic [LB:0]   CNT_ONE = (LB+1)'(1);

    state_t state, state_n;

    logic              act, incr, at_edge, last_now;
    logic [29:0]       base_addr, next_addr, exp_addr;
    logic [bl-1:0]     count, count_n, rd_len;
    logic              wr_accept, rd_ack, seen_last;
    logic              issue, iss_wr_n;
    logic [29:0]       iss_addr;
    logic [bl-1:0]     iss_len;

    logic              wpop, rpush, rpop, rclr;
    logic [dw+SW-1:0]  wbuf_dout;
    logic [dw:0]       rf_dout;
    logic [LB:0]       wcnt, rcnt;
    logic              wempty, rempty;

    assign act      = wb_stb_i & wb_cyc_i;
    assign incr     = wb_cti_i == CTI_INCR;
    assign at_edge  = &wb_addr_i[LB-1:0];
    assign last_now = sdr_rd_valid & sdr_last_rd;
    assign wempty   = wcnt == '0;
    assign rempty   = rcnt == '0;

`ifdef WB2SDRC_RD_PREFETCH_EN
    assign rd_len = incr ? BM_LEN - bl'(wb_addr_i[LB-1:0]) : LEN_ONE;
`else
    assign rd_len = LEN_ONE;
`endif

    always_comb begin
        state_n   = state;
        count_n   = count;
        wr_accept = 1'b0;
        rd_ack    = 1'b0;
        issue     = 1'b0;
        iss_addr  = base_addr;
        iss_len   = count;
        iss_wr_n  = 1'b0;
        wpop      = 1'b0;
        rpush     = 1'b0;
        rpop      = 1'b0;
        rclr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (act && wb_we_i) begin
                    wr_accept = 1'b1;
                    count_n   = LEN_ONE;
                    if (!incr || at_edge || BM_LEN == LEN_ONE) begin
                        issue    = 1'b1;
                        iss_addr = wb_addr_i;
                        iss_len  = LEN_ONE;
                        state_n  = WR_REQ;
                    end else begin
                        state_n = WR_COLLECT;
                    end
                end else if (act) begin
                    issue    = 1'b1;
                    iss_addr = wb_addr_i;
                    iss_len  = rd_len;
                    iss_wr_n = 1'b1;
                    state_n  = RD_REQ;
                end
            end
            WR_COLLECT: begin
                if (act && wb_we_i && wb_addr_i == next_addr) begin
                    wr_accept = 1'b1;
                    count_n   = count + LEN_ONE;
                    if (!incr || at_edge || count_n == BM_LEN) begin
                        issue   = 1'b1;
                        iss_len = count_n;
                        state_n = WR_REQ;
                    end
                end else begin
                    issue   = 1'b1;
                    state_n = WR_REQ;
                end
            end
            WR_REQ: begin
                wpop = sdr_wr_next && !wempty;
                if (sdr_req_ack) state_n = WR_DRAIN;
            end
            WR_DRAIN: begin
                wpop = sdr_wr_next && !wempty;
                if (wempty || (wpop && wcnt == CNT_ONE)) state_n = IDLE;
            end
            RD_REQ: begin
                rpush = sdr_rd_valid;
                if (sdr_req_ack) state_n = RD_DATA;
            end
            RD_DATA: begin
                rpush = sdr_rd_valid;
                if (act && !wb_we_i && wb_addr_i == exp_addr) begin
                    if (!rempty) begin
                        rd_ack = 1'b1;
                        rpop   = 1'b1;
                        // The final beat of the command ends the transfer cleanly.
                        if (rf_dout[dw])  state_n = IDLE;
                        else if (!incr)   state_n = RD_FLUSH;
                    end
                end else begin
                    state_n = RD_FLUSH;
                end
            end
            RD_FLUSH: begin
                rclr = 1'b1;
                if ((seen_last || last_now) && rempty) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state        <= IDLE;
            count        <= '0;
            base_addr    <= '0;
            next_addr    <= '0;
            exp_addr     <= '0;
            seen_last    <= 1'b0;
            sdr_req      <= 1'b0;
            sdr_req_addr <= '0;
            sdr_req_len  <= '0;
            sdr_req_wr_n <= 1'b1;
        end else begin
            state <= state_n;
            count <= count_n;
            if (wr_accept) next_addr <= wb_addr_i + 30'd1;
            if (wr_accept && state == IDLE) base_addr <= wb_addr_i;
            if (issue && iss_wr_n) exp_addr <= wb_addr_i;
            else if (rd_ack)       exp_addr <= exp_addr + 30'd1;
            if (issue)         seen_last <= 1'b0;
            else if (last_now) seen_last <= 1'b1;
            if (issue) begin
                sdr_req      <= 1'b1;
                sdr_req_addr <= iss_addr;
                sdr_req_len  <= iss_len;
                sdr_req_wr_n <= iss_wr_n;
            end else if (sdr_req_ack) begin
                sdr_req <= 1'b0;
            end
        end
    end

    wb2sdrc_sync_fifo #(.WIDTH(dw + SW), .DEPTH(BURST_MAX)) u_wbuf (
        .clk   (sdram_clk),
        .rst_n (sdram_resetn),
        .clr   (1'b0),
        .push  (wr_accept),
        .din   ({~wb_sel_i, wb_dat_i}),
        .pop   (wpop),
        .dout  (wbuf_dout),
        .count (wcnt)
    );

    wb2sdrc_sync_fifo #(.WIDTH(dw + 1), .DEPTH(BURST_MAX)) u_rfifo (
        .clk   (sdram_clk),
        .rst_n (sdram_resetn),
        .clr   (rclr),
        .push  (rpush),
        .din   ({sdr_last_rd, sdr_rd_data}),
        .pop   (rpop),
        .dout  (rf_dout),
        .count (rcnt)
    );

    // Empty buffers present idle values rather than stale storage.
    assign wb_ack_o    = sdram_resetn & (wr_accept | rd_ack);
    assign wb_dat_o    = rempty ? '0 : rf_dout[dw-1:0];
    assign sdr_wr_data = wempty ? '0 : wbuf_dout[dw-1:0];
    assign sdr_wr_en_n = wempty ? '1 : wbuf_dout[dw +: SW];

endmodule

// File: tb/tb_wb2sdrc_burst.sv
// Scoreboard bench for wb2sdrc_burst: directed Wishbone traffic against a
// small SDRAM-controller responder; monitors check commands, pops and read data.
module tb_wb2sdrc_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [29:0] wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        sdr_req;
    logic [29:0] sdr_req_addr;
    logic [8:0]  sdr_req_len;
    logic        sdr_req_wr_n;
    logic        sdr_req_ack;
    logic        sdr_wr_next;
    logic [3:0]  sdr_wr_en_n;
    logic [31:0] sdr_wr_data;
    logic        sdr_rd_valid;
    logic        sdr_last_rd;
    logic [31:0] sdr_rd_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [8:0]  len;
        logic        wr_n;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [35:0] wd_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int errors = 0;
    int cmd_seen = 0;
    int max_pops = 99;
    int rd_delay = 1;
    int vcyc = 0;
    int last_ack_cyc = 0;

    wb2sdrc_burst dut (
        .sdram_clk    (clk),
        .sdram_resetn (rst_n),
        .wb_stb_i     (wb_stb_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_sel_i     (wb_sel_i),
        .wb_cti_i     (wb_cti_i),
        .wb_ack_o     (wb_ack_o),
        .wb_dat_o     (wb_dat_o),
        .sdr_req      (sdr_req),
        .sdr_req_addr (sdr_req_addr),
        .sdr_req_len  (sdr_req_len),
        .sdr_req_wr_n (sdr_req_wr_n),
        .sdr_req_ack  (sdr_req_ack),
        .sdr_wr_next  (sdr_wr_next),
        .sdr_wr_en_n  (sdr_wr_en_n),
        .sdr_wr_data  (sdr_wr_data),
        .sdr_rd_valid (sdr_rd_valid),
        .sdr_last_rd  (sdr_last_rd),
        .sdr_rd_data  (sdr_rd_data)
    );

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endfunction

    task automatic exp_cmd(input logic [29:0] a, input logic [8:0] l, input logic w);
        cmd_t c;
        c.addr = a;
        c.len  = l;
        c.wr_n = w;
        cmd_q.push_back(c);
    endtask

    // SDRAM controller responder
    initial begin : sdram_model
        logic [29:0] a;
        logic [8:0]  l;
        logic        w;
        int          n;
        sdr_req_ack  = 1'b0;
        sdr_wr_next  = 1'b0;
        sdr_rd_valid = 1'b0;
        sdr_last_rd  = 1'b0;
        sdr_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (sdr_req === 1'b1) begin
                a = sdr_req_addr;
                l = sdr_req_len;
                w = sdr_req_wr_n;
                @(posedge clk); #1 sdr_req_ack = 1'b1;
                @(posedge clk); #1 sdr_req_ack = 1'b0;
                if (!w) begin
                    n = (int'(l) < max_pops) ? int'(l) : max_pops;
                    for (int i = 0; i < n; i++) begin
                        sdr_wr_next = 1'b1;
                        @(posedge clk); #1;
                    end
                    sdr_wr_next = 1'b0;
                end else begin
                    repeat (rd_delay) begin
                        @(posedge clk); #1;
                    end
                    for (int i = 0; i < int'(l); i++) begin
                        if (i == 0) vcyc = cyc;
                        sdr_rd_valid = 1'b1;
                        sdr_last_rd  = (i == int'(l) - 1);
                        sdr_rd_data  = 32'hD000_0000 | {2'b00, a + 30'(i)};
                        @(posedge clk); #1;
                    end
                    sdr_rd_valid = 1'b0;
                    sdr_last_rd  = 1'b0;
                end
            end
        end
    end

    // Monitor: commands, write pops and read acks
    always @(negedge clk) begin
        if (rst_n) begin
            if (sdr_req && sdr_req_ack) begin
                cmd_t e;
                cmd_seen++;
                if (cmd_q.size() == 0) begin
                    fail("cmd_unexpected");
                end else begin
                    e = cmd_q.pop_front();
                    chk("cmd_addr", 64'(sdr_req_addr), 64'(e.addr));
                    chk("cmd_len", 64'(sdr_req_len), 64'(e.len));
                    chk("cmd_wr_n", 64'(sdr_req_wr_n), 64'(e.wr_n));
                end
            end
            if (sdr_wr_next) begin
                if (wd_q.size() == 0) fail("wr_pop_unexpected");
                else chk("wr_beat", 64'({sdr_wr_en_n, sdr_wr_data}), 64'(wd_q.pop_front()));
            end
            if (wb_ack_o && !wb_we_i) begin
                if (rd_q.size() == 0) fail("rd_ack_unexpected");
                else chk("rd_data", 64'(wb_dat_o), 64'(rd_q.pop_front()));
            end
        end
    end

    task automatic wb_write(input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] c, output int waits);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = 1'b1;
        wb_addr_i = a;
        wb_dat_i  = d;
        wb_sel_i  = s;
        wb_cti_i  = c;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            if (wb_ack_o) break;
            waits++;
            if (waits >= 100) begin
                fail("wr_ack_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [29:0] a, input logic [2:0] c, input logic [31:0] e);
        int waits;
        rd_q.push_back(e);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = 1'b0;
        wb_addr_i = a;
        wb_sel_i  = 4'hF;
        wb_cti_i  = c;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            if (wb_ack_o) begin
                last_ack_cyc = cyc;
                break;
            end
            waits++;
            if (waits >= 100) begin
                fail("rd_ack_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((cmd_q.size() + wd_q.size() + rd_q.size()) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 300) fail({nm, "_drain_timeout"});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 64'(sdr_req), 64'd0);
        chk({tag, "_req_addr"}, 64'(sdr_req_addr), 64'd0);
        chk({tag, "_req_len"}, 64'(sdr_req_len), 64'd0);
        chk({tag, "_req_wr_n"}, 64'(sdr_req_wr_n), 64'd1);
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
        chk({tag, "_dat_o"}, 64'(wb_dat_o), 64'd0);
        chk({tag, "_wr_en_n"}, 64'(sdr_wr_en_n), 64'hF);
        chk({tag, "_wr_data"}, 64'(sdr_wr_data), 64'd0);
    endtask

    initial begin
        int w;
        int c0;
        int t;
        wb_stb_i  = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_addr_i = '0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        wb_cti_i  = '0;
        repeat (3) @(posedge clk);
        #1 check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Classic single write
        exp_cmd(30'h100, 9'd1, 1'b0);
        wd_q.push_back({4'b1100, 32'h1122_3344});
        wb_write(30'h100, 32'h1122_3344, 4'b0011, 3'b000, w);
        chk("t1_wr_wait", 64'(w), 64'd0);
        idle();
        drain("t1");

        // Eight-beat incrementing burst
        exp_cmd(30'h200, 9'd8, 1'b0);
        for (int i = 0; i < 8; i++) wd_q.push_back({4'b0000, 32'hB000_0000 + 32'(i)});
        for (int i = 0; i < 8; i++) begin
            wb_write(30'h200 + 30'(i), 32'hB000_0000 + 32'(i), 4'hF, 3'b010, w);
            chk("t2_wr_wait", 64'(w), 64'd0);
        end
        idle();
        drain("t2");

        // Burst crossing an aligned boundary splits into two commands
        exp_cmd(30'h206, 9'd2, 1'b0);
        exp_cmd(30'h208, 9'd2, 1'b0);
        for (int i = 6; i < 10; i++) wd_q.push_back({4'b0000, 32'hA000_0200 + 32'(i)});
        wb_write(30'h206, 32'hA000_0206, 4'hF, 3'b010, w);
        chk("t3_wr_wait0", 64'(w), 64'd0);
        wb_write(30'h207, 32'hA000_0207, 4'hF, 3'b010, w);
        chk("t3_wr_wait1", 64'(w), 64'd0);
        wb_write(30'h208, 32'hA000_0208, 4'hF, 3'b010, w);
        wb_write(30'h209, 32'hA000_0209, 4'hF, 3'b111, w);
        chk("t3_wr_wait3", 64'(w), 64'd0);
        idle();
        drain("t3");

        // Incrementing read abandoned after two beats
`ifdef WB2SDRC_RD_PREFETCH_EN
        exp_cmd(30'h103, 9'd5, 1'b1);
`else
        exp_cmd(30'h103, 9'd1, 1'b1);
        exp_cmd(30'h104, 9'd1, 1'b1);
`endif
        exp_cmd(30'h200, 9'd1, 1'b1);
        wb_read(30'h103, 3'b010, 32'hD000_0103);
        wb_read(30'h104, 3'b111, 32'hD000_0104);
        repeat (4) idle();
        wb_read(30'h200, 3'b000, 32'hD000_0200);
        idle();
        drain("t4");

        // Slow read return
        rd_delay = 10;
        exp_cmd(30'h180, 9'd1, 1'b1);
        wb_read(30'h180, 3'b000, 32'hD000_0180);
        chk("t5_first_ack_cycle", 64'(last_ack_cyc), 64'(vcyc + 1));
        rd_delay = 1;
        idle();
        drain("t5");

        // Reset while a write command still holds three beats
        max_pops = 0;
        c0 = cmd_seen;
        exp_cmd(30'h300, 9'd3, 1'b0);
        wb_write(30'h300, 32'hC000_0300, 4'b0101, 3'b010, w);
        wb_write(30'h301, 32'hC000_0301, 4'b0101, 3'b010, w);
        wb_write(30'h302, 32'hC000_0302, 4'b0101, 3'b111, w);
        idle();
        t = 0;
        while (cmd_seen == c0 && t < 50) begin
            idle();
            t++;
        end
        if (t >= 50) fail("t6_cmd_timeout");
        repeat (2) idle();
        chk("t6_pending_en_n", 64'(sdr_wr_en_n), 64'hA);
        chk("t6_pending_data", 64'(sdr_wr_data), 64'hC000_0300);
        #2 rst_n = 1'b0;
        #1 check_reset("t6");
        @(posedge clk); #1;
        rst_n = 1'b1;
        max_pops = 99;
        @(posedge clk); #1;
        exp_cmd(30'h400, 9'd1, 1'b0);
        wd_q.push_back({4'b0000, 32'h5555_AAAA});
        wb_write(30'h400, 32'h5555_AAAA, 4'hF, 3'b000, w);
        chk("t6_wr_wait", 64'(w), 64'd0);
        idle();
        drain("t6");

        repeat (5) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
